// File: rtl/pwls_param_writer.sv
// Byte-stream parameter writer for a piecewise-linear synth voice.
// Three-byte frames (address, data low, data high) load shadow registers.
// A commit request in the address byte copies every shadow to the live
// outputs in one cycle, so a voice never sees a half-updated parameter set.
// Handshake: a byte moves on a rising edge where in_valid && in_ready; the
// producer holds in_data stable while in_valid is high, and the writer only
// drops in_ready for the single COMMIT cycle.
module pwls_param_writer #(
  parameter int BITS            = 12,
  parameter int OCT_BITS        = 3,
  parameter int DETUNE_EXP_BITS = 3,
  parameter int SLOPE_EXP_BITS  = 4,
  parameter int MODE_BITS       = 2,
  parameter int TIMEOUT         = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic [BITS-2:0]            mantissa,
  output logic [OCT_BITS-1:0]        octave,
  output logic [DETUNE_EXP_BITS-1:0] detune_exp,
  output logic [BITS-1:0]            tri_offset,
  output logic [SLOPE_EXP_BITS-1:0]  slope_exp,
  output logic [BITS-4:0]            slope_offset,
  output logic [BITS-3:0]            amp,
  output logic [MODE_BITS-1:0]       channel_mode,
  output logic                       update,
  output logic [1:0]                 err,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LO     = 2'd1,
    S_HI     = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] idle_cnt;
  logic          commit_req;
  logic [2:0]    reg_sel;
  logic [7:0]    lo_q;

  // Shadow copies of every parameter
  logic [BITS-2:0]            sh_mantissa;
  logic [OCT_BITS-1:0]        sh_octave;
  logic [DETUNE_EXP_BITS-1:0] sh_detune_exp;
  logic [BITS-1:0]            sh_tri_offset;
  logic [SLOPE_EXP_BITS-1:0]  sh_slope_exp;
  logic [BITS-4:0]            sh_slope_offset;
  logic [BITS-3:0]            sh_amp;
  logic [MODE_BITS-1:0]       sh_channel_mode;

  logic        accept;
  logic        hi_wr;
  logic [15:0] data_word;
  // Zero-padded so field slices stay legal when parameters widen past 16 bits
  logic [63:0] d_ext;
  logic        unused_d_ext;

  assign accept       = in_valid && in_ready;
  assign hi_wr        = accept && (state == S_HI);
  assign data_word    = {in_data, lo_q};
  assign d_ext        = {48'd0, data_word};
  assign unused_d_ext = ^d_ext;
  assign dbg_state    = state;

  // Frame sequencing, idle timeout, sticky error flags and update pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idle_cnt   <= '0;
      commit_req <= 1'b0;
      reg_sel    <= 3'd0;
      lo_q       <= 8'd0;
      err        <= 2'b00;
      update     <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      update <= 1'b0;
      case (state)
        S_IDLE: begin
          idle_cnt <= '0;
          if (accept) begin
            if (in_data[6]) begin
              // Control frame: single byte, clears the error flags
              err <= 2'b00;
            end else begin
              commit_req <= in_data[7];
              reg_sel    <= in_data[2:0];
              state      <= S_LO;
            end
          end
        end
        S_LO: begin
          if (accept) begin
            lo_q     <= in_data;
            idle_cnt <= '0;
            state    <= S_HI;
          end else if (idle_cnt == TO_LAST) begin
            idle_cnt <= '0;
            err[1]   <= 1'b1;
            state    <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_HI: begin
          if (accept) begin
            idle_cnt <= '0;
            if (reg_sel > 3'd4) err[0] <= 1'b1;
            if (commit_req) begin
              state    <= S_COMMIT;
              in_ready <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else if (idle_cnt == TO_LAST) begin
            idle_cnt <= '0;
            err[1]   <= 1'b1;
            state    <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        S_COMMIT: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
          update   <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  // Shadow registers load on the edge that accepts the high data byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_mantissa     <= '0;
      sh_octave       <= '0;
      sh_detune_exp   <= '0;
      sh_tri_offset   <= '0;
      sh_slope_exp    <= '0;
      sh_slope_offset <= '0;
      sh_amp          <= '1;
      sh_channel_mode <= '0;
    end else if (hi_wr) begin
      case (reg_sel)
        3'd0: begin
          sh_mantissa <= d_ext[BITS-2:0];
          sh_octave   <= d_ext[BITS-1 +: OCT_BITS];
        end
        3'd1: sh_tri_offset <= d_ext[BITS-1:0];
        3'd2: sh_amp        <= d_ext[BITS-3:0];
        3'd3: begin
          sh_slope_offset <= d_ext[BITS-4:0];
          sh_slope_exp    <= d_ext[BITS-3 +: SLOPE_EXP_BITS];
        end
        3'd4: begin
          sh_detune_exp   <= d_ext[DETUNE_EXP_BITS-1:0];
          sh_channel_mode <= d_ext[DETUNE_EXP_BITS +: MODE_BITS];
        end
        default: ;
      endcase
    end
  end

  // Live outputs take the whole shadow set at the end of the COMMIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mantissa     <= '0;
      octave       <= '0;
      detune_exp   <= '0;
      tri_offset   <= '0;
      slope_exp    <= '0;
      slope_offset <= '0;
      amp          <= '1;
      channel_mode <= '0;
    end else if (state == S_COMMIT) begin
      mantissa     <= sh_mantissa;
      octave       <= sh_octave;
      detune_exp   <= sh_detune_exp;
      tri_offset   <= sh_tri_offset;
      slope_exp    <= sh_slope_exp;
      slope_offset <= sh_slope_offset;
      amp          <= sh_amp;
      channel_mode <= sh_channel_mode;
    end
  end

endmodule

// File: tb/tb_pwls_param_writer.sv
// Directed bench for pwls_param_writer with hand-computed expectations.
module tb_pwls_param_writer;

  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [10:0] mantissa;
  logic [2:0]  octave;
  logic [2:0]  detune_exp;
  logic [11:0] tri_offset;
  logic [3:0]  slope_exp;
  logic [8:0]  slope_offset;
  logic [9:0]  amp;
  logic [1:0]  channel_mode;
  logic        update;
  logic [1:0]  err;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  pwls_param_writer #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mantissa     (mantissa),
    .octave       (octave),
    .detune_exp   (detune_exp),
    .tri_offset   (tri_offset),
    .slope_exp    (slope_exp),
    .slope_offset (slope_offset),
    .amp          (amp),
    .channel_mode (channel_mode),
    .update       (update),
    .err          (err),
    .dbg_state    (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge, sample 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until accepted (bounded wait)
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL send_byte_timeout got in_ready=%0b exp 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (mantissa !== 11'd0 || octave !== 3'd0 || tri_offset !== 12'd0 || amp !== 10'h3FF) begin
      errors++;
      $display("FAIL reset_params got m=%h o=%h t=%h a=%h exp 0 0 0 3ff", mantissa, octave, tri_offset, amp);
    end
    checks++;
    if (slope_exp !== 4'd0 || slope_offset !== 9'd0 || detune_exp !== 3'd0 || channel_mode !== 2'd0) begin
      errors++;
      $display("FAIL reset_params2 got se=%h so=%h de=%h cm=%h exp 0", slope_exp, slope_offset, detune_exp, channel_mode);
    end
    checks++;
    if (in_ready !== 1'b1 || update !== 1'b0 || err !== 2'b00 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctrl got rdy=%b upd=%b err=%b st=%0d exp 1 0 00 0", in_ready, update, err, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h80);
    send_byte(8'h34);
    send_byte(8'h12);
    checks++;
    if (in_ready !== 1'b0 || dbg_state !== 2'd3 || mantissa !== 11'd0 || update !== 1'b0) begin
      errors++;
      $display("FAIL b2b_commit_cycle got rdy=%b st=%0d m=%h upd=%b exp 0 3 0 0", in_ready, dbg_state, mantissa, update);
    end
    tick();
    checks++;
    if (mantissa !== 11'h234 || octave !== 3'd2 || update !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_commit got m=%h o=%h upd=%b rdy=%b exp 234 2 1 1", mantissa, octave, update, in_ready);
    end
    tick();
    checks++;
    if (update !== 1'b0) begin
      errors++;
      $display("FAIL b2b_update_width got %b exp 0", update);
    end
  endtask

  task automatic test_shadow_then_commit();
    int pulses;
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'h0F);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (update === 1'b1) pulses++;
    end
    checks++;
    if (tri_offset !== 12'd0 || pulses != 0) begin
      errors++;
      $display("FAIL shadow_hold got t=%h pulses=%0d exp 0 0", tri_offset, pulses);
    end
    send_byte(8'h82);
    send_byte(8'h00);
    send_byte(8'h02);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (update === 1'b1) pulses++;
    end
    checks++;
    if (tri_offset !== 12'hFFF || amp !== 10'h200 || pulses != 1) begin
      errors++;
      $display("FAIL shadow_commit got t=%h a=%h pulses=%0d exp fff 200 1", tri_offset, amp, pulses);
    end
  endtask

  task automatic test_detune_mode();
    send_byte(8'h84);
    send_byte(8'h1D);
    send_byte(8'h00);
    tick();
    checks++;
    if (detune_exp !== 3'd5 || channel_mode !== 2'd3 || mantissa !== 11'h234) begin
      errors++;
      $display("FAIL detune_mode got de=%h cm=%h m=%h exp 5 3 234", detune_exp, channel_mode, mantissa);
    end
  endtask

  task automatic test_bad_addr();
    send_byte(8'h85);
    send_byte(8'hAA);
    send_byte(8'hBB);
    checks++;
    if (err !== 2'b01) begin
      errors++;
      $display("FAIL bad_addr_err got %b exp 01", err);
    end
    tick();
    checks++;
    if (update !== 1'b1 || tri_offset !== 12'hFFF || amp !== 10'h200 || mantissa !== 11'h234 || detune_exp !== 3'd5) begin
      errors++;
      $display("FAIL bad_addr_commit got upd=%b t=%h a=%h m=%h de=%h exp 1 fff 200 234 5", update, tri_offset, amp, mantissa, detune_exp);
    end
    send_byte(8'h40);
    checks++;
    if (err !== 2'b00 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL ctrl_clear got err=%b st=%0d exp 00 0", err, dbg_state);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'h03);
    send_byte(8'h11);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    checks++;
    if (err !== 2'b00 || dbg_state !== 2'd2) begin
      errors++;
      $display("FAIL timeout_early got err=%b st=%0d exp 00 2", err, dbg_state);
    end
    tick();
    checks++;
    if (err !== 2'b10 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL timeout_fire got err=%b st=%0d exp 10 0", err, dbg_state);
    end
    send_byte(8'h83);
    send_byte(8'h00);
    send_byte(8'h00);
    tick();
    checks++;
    if (slope_exp !== 4'd0 || slope_offset !== 9'd0 || update !== 1'b1) begin
      errors++;
      $display("FAIL timeout_next_frame got se=%h so=%h upd=%b exp 0 0 1", slope_exp, slope_offset, update);
    end
  endtask

  task automatic test_accept_wins();
    send_byte(8'h40);
    send_byte(8'h83);
    send_byte(8'h01);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    send_byte(8'h2A);
    checks++;
    if (dbg_state !== 2'd3 || err !== 2'b00) begin
      errors++;
      $display("FAIL accept_wins_state got st=%0d err=%b exp 3 00", dbg_state, err);
    end
    tick();
    checks++;
    if (slope_exp !== 4'd5 || slope_offset !== 9'd1 || update !== 1'b1) begin
      errors++;
      $display("FAIL accept_wins_commit got se=%h so=%h upd=%b exp 5 1 1", slope_exp, slope_offset, update);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h87);
    send_byte(8'h00);
    send_byte(8'h00);
    tick();
    send_byte(8'h80);
    send_byte(8'h55);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (amp !== 10'h3FF || tri_offset !== 12'd0 || mantissa !== 11'd0 || slope_exp !== 4'd0 || err !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_params got a=%h t=%h m=%h se=%h err=%b exp 3ff 0 0 0 00", amp, tri_offset, mantissa, slope_exp, err);
    end
    checks++;
    if (dbg_state !== 2'd0 || in_ready !== 1'b1 || update !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ctrl got st=%0d rdy=%b upd=%b exp 0 1 0", dbg_state, in_ready, update);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_byte(8'h80);
    send_byte(8'h01);
    send_byte(8'h00);
    tick();
    checks++;
    if (mantissa !== 11'd1 || octave !== 3'd0 || amp !== 10'h3FF || tri_offset !== 12'd0 || update !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_next got m=%h o=%h a=%h t=%h upd=%b exp 1 0 3ff 0 1", mantissa, octave, amp, tri_offset, update);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    test_back_to_back();
    test_shadow_then_commit();
    test_detune_mode();
    test_bad_addr();
    test_timeout();
    test_accept_wins();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwls_param_writer.md
PWLS_PARAM_WRITER -- requirements
Module: pwls_param_writer

Interface
REQ-001 Parameters SHALL be: BITS, default 12, sample/parameter word width.
REQ-002 OCT_BITS, default 3, octave field width.
REQ-003 DETUNE_EXP_BITS, default 3, detune exponent width.
REQ-004 SLOPE_EXP_BITS, default 4, slope exponent width.
REQ-005 MODE_BITS, default 2, channel_mode width.
REQ-006 TIMEOUT, default 255, idle cycles allowed between bytes of one frame.
REQ-007 One clock; reset is asynchronous and active-low: clk  in  1  clock; rst_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  byte offered; in_data  in  8  byte; in_ready  out  1  byte accepted when in_valid && in_ready.
REQ-009 Outputs SHALL be mantissa (BITS-1), octave (OCT_BITS), detune_exp (DETUNE_EXP_BITS), tri_offset (BITS), slope_exp (SLOPE_EXP_BITS), slope_offset (BITS-3), amp (BITS-2), channel_mode (MODE_BITS), all live (committed) values.
REQ-010 update  out  1  one-cycle pulse when live values are committed; err  out  2  sticky flags: [0] bad address, [1] timeout.

Function
REQ-011 Frame format: address byte A, data low byte, data high byte; D = {high, low}, 16 bits.
REQ-012 A[6]=1 SHALL be a one-byte control frame that clears err to 0; A[5:0] and A[7] ignored; FSM stays IDLE.
REQ-013 A[2:0] selects register: 0 {octave=D[13:11], mantissa=D[10:0]}; 1 tri_offset=D[11:0]; 2 amp=D[9:0]; 3 {slope_exp=D[12:9], slope_offset=D[8:0]}; 4 {channel_mode=D[4:3], detune_exp=D[2:0]}; unused D bits ignored (slices scale with parameters).
REQ-014 A[2:0] in 5..7: both data bytes still consumed, no register written, err[0] set on high-byte acceptance.
REQ-015 A[7]=1 requests commit after the frame's data write.
REQ-016 Writes SHALL go to shadow registers; outputs change only on commit.
REQ-017 FSM states IDLE, LO, HI, COMMIT; IDLE --accept A (A[6]=0)--> LO; LO --accept--> HI; HI --accept--> COMMIT if A[7] else IDLE; COMMIT --> IDLE unconditionally after one cycle.
REQ-018 Shadow write SHALL occur on the clock edge accepting the high byte.
REQ-019 In COMMIT: in_ready=0; all shadows copied to live on that edge; update=1 in the following cycle only (registered).
REQ-020 Commit with invalid address SHALL still copy shadows to live and pulse update.
REQ-021 in_ready=1 in IDLE, LO, HI.
REQ-022 Timeout counter cleared on every accepted byte and on entering LO; increments each cycle in LO/HI without acceptance; when it reaches TIMEOUT, FSM SHALL return to IDLE, discard the partial frame (no shadow write), set err[1].
REQ-023 Byte accepted in the same cycle the counter would reach TIMEOUT SHALL be honoured (acceptance wins).
REQ-024 err bits sticky until control frame or reset; setting and clearing in same cycle impossible (distinct states).
REQ-025 Latency: high byte accepted at edge N with commit -> outputs updated at edge N+1, update high during cycle after N+1.

Reset
REQ-026 rst_n low SHALL asynchronously force FSM=IDLE, counter=0, err=0, update=0, in_ready to IDLE value.
REQ-027 Reset values for live and shadow: amp all ones; every other parameter 0.
REQ-028 Reset mid-frame SHALL discard the partial frame and any uncommitted shadow writes.

Verification
REQ-029 Bytes 0x80,0x34,0x12 back-to-back -> octave=2, mantissa=0x234 one edge after high byte, update single pulse, in_ready low exactly one cycle.
REQ-030 Frames 0x01,0xFF,0x0F then 0x82,0x00,0x02 -> tri_offset stays 0 after first frame; after second, tri_offset=0xFFF, amp=0x200, one update pulse.
REQ-031 0x85,0xAA,0xBB -> err=2'b01, no parameter change, update pulses; then 0x40 -> err=0.
REQ-032 0x03, 0x11, then in_valid low TIMEOUT cycles -> err[1]=1, FSM IDLE; next 0x83,0x00,0x00 commits slope_exp=0, slope_offset=0 (stale 0x11 never written).
REQ-033 rst_n low while in HI after 0x80,0x55 -> outputs at reset values (amp=0x3FF), err=0; next full frame behaves normally.
